tbce_crc_attach: RTL and testbench

//  Upstream stage of the tail-biting conv encoder: buffers one payload frame and computes CRC-16.

---
 rtl/tbce_crc_attach_pkg.sv | 22 ++
 rtl/tbce_crc_attach_if.sv | 40 ++++
 rtl/tbce_crc_attach_crc16_serial.sv | 37 +++
 rtl/tbce_crc_attach.sv | 186 ++++++++++++++++++
 tb/tb_tbce_crc_attach.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tbce_crc_attach_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tbce_crc_attach_pkg
// Description : Shared constants and FSM state type for the CRC attach stage.
// Revision    : 1.0 - initial release
// ============================================================================
package tbce_crc_attach_pkg;

  localparam int unsigned     C_CRC_WIDTH     = 16;
  localparam logic [15:0]     C_CRC16_POLY    = 16'h1021;
  localparam int unsigned     C_TB_INIT_WIDTH = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INIT = 3'd2,
    ST_DATA = 3'd3,
    ST_CRC  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tbce_crc_attach_if.sv
`default_nettype none
// ============================================================================
// Module      : tbce_crc_attach_if
// Description : Payload-in / stream-out bundle of the CRC attach stage.
//               crc_mask exists only when TBCE_CRC_MASK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface tbce_crc_attach_if;
  import tbce_crc_attach_pkg::*;

  logic                       din;
  logic                       din_vld;
  logic                       din_last;
  logic                       din_rdy;
  logic                       dout;
  logic                       dout_vld;
  logic [C_TB_INIT_WIDTH-1:0] dout_init;
  logic                       err;
`ifdef TBCE_CRC_MASK_EN
  logic [C_CRC_WIDTH-1:0]     crc_mask;
`endif

  modport master (
    output din, din_vld, din_last,
    input  din_rdy, dout, dout_vld, dout_init, err
`ifdef TBCE_CRC_MASK_EN
    , output crc_mask
`endif
  );

  modport slave (
    input  din, din_vld, din_last,
    output din_rdy, dout, dout_vld, dout_init, err
`ifdef TBCE_CRC_MASK_EN
    , input crc_mask
`endif
  );

endinterface
`default_nettype wire

// File: rtl/tbce_crc_attach_crc16_serial.sv
`default_nettype none
// ============================================================================
// Module      : tbce_crc_attach_crc16_serial
// Description : Bit-serial CRC LFSR (crc16_serial), MSB-first, init 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tbce_crc_attach_crc16_serial #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h1021
) (
  input  wire logic             clk_i,
  input  wire logic             rst_n,
  input  wire logic             clr,
  input  wire logic             en,
  input  wire logic             din,
  output logic      [WIDTH-1:0] crc
);

  logic [WIDTH-1:0] r_crc;
  logic             w_fb;

  assign w_fb = r_crc[WIDTH-1] ^ din;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (clr) begin
      r_crc <= '0;
    end else if (en) begin
      r_crc <= {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

  assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/tbce_crc_attach.sv
`default_nettype none
// ============================================================================
// Module      : tbce_crc_attach
// Description : Buffers one payload frame, appends CRC-16 and presents the
//               tail-biting init state; optional CRC scrambling via
//               TBCE_CRC_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tbce_crc_attach
  import tbce_crc_attach_pkg::*;
#(
  parameter int unsigned          MAX_PLD_LEN = 128,
  parameter int unsigned          CNT_WIDTH   = 8,
  parameter int unsigned          CRC_WIDTH   = C_CRC_WIDTH,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY    = C_CRC16_POLY,
  parameter int unsigned          INIT_WIDTH  = C_TB_INIT_WIDTH
) (
  input wire logic         clk_i,
  input wire logic         rst_n,
  tbce_crc_attach_if.slave io
);

  localparam int unsigned          c_addr_w   = (MAX_PLD_LEN > 1) ? $clog2(MAX_PLD_LEN) : 1;
  localparam logic [CNT_WIDTH-1:0] c_max_cnt  = CNT_WIDTH'(MAX_PLD_LEN);
  localparam logic [CNT_WIDTH-1:0] c_crc_last = CNT_WIDTH'(CRC_WIDTH - 1);

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_len, w_len_nxt;
  logic [CRC_WIDTH-1:0]  r_crc_out, w_crc_out_nxt;
  logic [INIT_WIDTH-1:0] r_dout_init, w_dout_init_nxt;
  logic                  r_dout, w_dout_nxt;
  logic                  r_dout_vld, w_dout_vld_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_crc_clr, w_crc_en, w_buf_we;
  logic [CRC_WIDTH-1:0]  w_crc, w_mask;
  logic [c_addr_w-1:0]   w_addr;
  logic                  r_buf [MAX_PLD_LEN];

`ifdef TBCE_CRC_MASK_EN
  assign w_mask = io.crc_mask;
`else
  assign w_mask = '0;
`endif

  assign w_addr = r_cnt[c_addr_w-1:0];

  tbce_crc_attach_crc16_serial #(
    .WIDTH (CRC_WIDTH),
    .POLY  (CRC_POLY)
  ) u_crc (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr   (w_crc_clr),
    .en    (w_crc_en),
    .din   (io.din),
    .crc   (w_crc)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_len_nxt       = r_len;
    w_crc_out_nxt   = r_crc_out;
    w_dout_init_nxt = r_dout_init;
    w_dout_nxt      = 1'b0;
    w_dout_vld_nxt  = 1'b0;
    w_err_nxt       = 1'b0;
    w_crc_clr       = 1'b0;
    w_crc_en        = 1'b0;
    w_buf_we        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (io.din_vld) begin
          w_buf_we  = 1'b1;
          w_crc_en  = 1'b1;
          w_cnt_nxt = CNT_WIDTH'(1);
          if (io.din_last) begin
            w_len_nxt   = CNT_WIDTH'(1);
            w_state_nxt = ST_INIT;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (io.din_vld) begin
          // A full buffer cannot take another bit, so it is dropped even if it is marked last.
          if (r_cnt == c_max_cnt) begin
            w_err_nxt   = 1'b1;
            w_crc_clr   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_buf_we  = 1'b1;
            w_crc_en  = 1'b1;
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
            if (io.din_last) begin
              w_len_nxt   = r_cnt + CNT_WIDTH'(1);
              w_state_nxt = ST_INIT;
            end
          end
        end
      end

      ST_INIT: begin
        w_err_nxt     = io.din_vld;
        w_crc_out_nxt = w_crc ^ w_mask;
        for (int k = 0; k < INIT_WIDTH; k++) begin
          w_dout_init_nxt[k] = w_crc_out_nxt[INIT_WIDTH-1-k];
        end
        w_crc_clr   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_DATA;
      end

      ST_DATA: begin
        w_err_nxt      = io.din_vld;
        w_dout_nxt     = r_buf[w_addr];
        w_dout_vld_nxt = 1'b1;
        if (r_cnt == r_len - CNT_WIDTH'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_CRC;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end

      ST_CRC: begin
        w_err_nxt      = io.din_vld;
        w_dout_nxt     = r_crc_out[CRC_WIDTH-1];
        w_dout_vld_nxt = 1'b1;
        w_crc_out_nxt  = {r_crc_out[CRC_WIDTH-2:0], 1'b0};
        if (r_cnt == c_crc_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_crc_out   <= '0;
      r_dout_init <= '0;
      r_dout      <= 1'b0;
      r_dout_vld  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len       <= w_len_nxt;
      r_crc_out   <= w_crc_out_nxt;
      r_dout_init <= w_dout_init_nxt;
      r_dout      <= w_dout_nxt;
      r_dout_vld  <= w_dout_vld_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_buf_we) begin
      r_buf[w_addr] <= io.din;
    end
  end

  assign io.din_rdy   = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign io.dout      = r_dout;
  assign io.dout_vld  = r_dout_vld;
  assign io.dout_init = r_dout_init;
  assign io.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tbce_crc_attach.sv
`default_nettype none
// ============================================================================
// Module      : tb_tbce_crc_attach
// Description : Self-checking bench for tbce_crc_attach against a polynomial-
//               division CRC model; mask scenarios need TBCE_CRC_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tbce_crc_attach;

  typedef bit bitq_t[$];

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   err_cnt = 0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  bit   got[$];
  bit   exp_q[$];
  logic [5:0]  exp_init;
  logic [15:0] cur_mask = 16'h0;

  tbce_crc_attach_if io ();

  tbce_crc_attach dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor on the falling edge
  always @(negedge clk) begin
    if (io.dout_vld === 1'b1) begin
      if (got.size() == 0) first_cyc <= cyc;
      got.push_back(io.dout);
      last_cyc <= cyc;
    end
    if (io.err === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // CRC as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
  function automatic logic [15:0] ref_crc(input bitq_t m);
    bit [16:0] r = '0;
    for (int i = 0; i < m.size() + 16; i++) begin
      r = {r[15:0], (i < m.size()) ? m[i] : 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  function automatic void make_expected(input bitq_t m, input logic [15:0] mask);
    logic [15:0] c;
    int n;
    c = ref_crc(m) ^ mask;
    exp_q = m;
    for (int b = 15; b >= 0; b--) exp_q.push_back(c[b]);
    n = exp_q.size();
    for (int k = 0; k < 6; k++) exp_init[k] = exp_q[n-6+k];
  endfunction

  task automatic set_mask(input logic [15:0] m);
    cur_mask = m;
`ifdef TBCE_CRC_MASK_EN
    io.crc_mask = m;
`endif
  endtask

  task automatic clear_mon();
    got.delete();
    first_cyc = -1;
    last_cyc  = -1;
  endtask

  // Drive one frame, one bit per cycle; returns the cycle of the last accepted bit
  task automatic send_frame(input bitq_t bits, input bit with_last, output int t_last);
    for (int i = 0; i < bits.size(); i++) begin
      io.din      = bits[i];
      io.din_vld  = 1'b1;
      io.din_last = with_last && (i == bits.size() - 1);
      @(posedge clk); #1;
    end
    io.din_vld  = 1'b0;
    io.din_last = 1'b0;
    io.din      = 1'b0;
    t_last = cyc;
  endtask

  task automatic wait_stream(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    io.din = 1'b0; io.din_vld = 1'b0; io.din_last = 1'b0;
    set_mask(16'h0);
    #23;
    checks++; if (io.dout !== 1'b0)      begin errors++; $display("FAIL rst_dout: got %b want 0", io.dout); end
    checks++; if (io.dout_vld !== 1'b0)  begin errors++; $display("FAIL rst_dout_vld: got %b want 0", io.dout_vld); end
    checks++; if (io.dout_init !== 6'b0) begin errors++; $display("FAIL rst_dout_init: got %b want 000000", io.dout_init); end
    checks++; if (io.err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %b want 0", io.err); end
    checks++; if (io.din_rdy !== 1'b1)   begin errors++; $display("FAIL rst_din_rdy: got %b want 1", io.din_rdy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vector(input logic [15:0] mask, input logic [15:0] want_crc, input logic [5:0] want_init);
    bitq_t m; string s = "123456789"; logic [7:0] ch; logic [15:0] f = '0; int t; int bad = 0;
    set_mask(mask); clear_mon();
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      for (int b = 7; b >= 0; b--) m.push_back(ch[b]);
    end
    make_expected(m, mask);
    send_frame(m, 1'b1, t);
    @(posedge clk); #1;
    checks++; if (io.dout_init !== want_init) begin errors++; $display("FAIL vec_init: got %b want %b", io.dout_init, want_init); end
    wait_stream(88, 300);
    checks++; if (io.dout_vld !== 1'b0) begin errors++; $display("FAIL vec_gap: dout_vld %b want 0", io.dout_vld); end
    checks++; if (first_cyc != t + 2) begin errors++; $display("FAIL vec_latency: first valid at %0d want %0d", first_cyc, t + 2); end
    for (int i = 72; i < 88; i++) if (i < got.size()) f = {f[14:0], got[i]};
    checks++; if (f !== want_crc) begin errors++; $display("FAIL vec_crc: got %h want %h", f, want_crc); end
    for (int i = 0; i < exp_q.size(); i++) if (i < got.size() && got[i] !== exp_q[i]) bad++;
    checks++; if (got.size() != 88 || bad != 0 || last_cyc - first_cyc + 1 != got.size())
      begin errors++; $display("FAIL vec_stream: %0d bits (%0d wrong, span %0d) want 88 contiguous", got.size(), bad, last_cyc - first_cyc + 1); end
    set_mask(16'h0);
  endtask

  task automatic test_zeros();
    bitq_t m; int t; int bad = 0;
    clear_mon();
    for (int i = 0; i < 16; i++) m.push_back(1'b0);
    send_frame(m, 1'b1, t);
    @(posedge clk); #1;
    checks++; if (io.dout_init !== 6'b000000) begin errors++; $display("FAIL zero_init: got %b want 000000", io.dout_init); end
    wait_stream(32, 200);
    for (int i = 0; i < got.size(); i++) if (got[i] !== 1'b0) bad++;
    checks++; if (got.size() != 32 || bad != 0) begin errors++; $display("FAIL zero_stream: %0d bits, %0d ones, want 32 zeros", got.size(), bad); end
    repeat (3) @(posedge clk); #1;
    checks++; if (got.size() != 32) begin errors++; $display("FAIL zero_tail: %0d valid bits want 32", got.size()); end
  endtask

  task automatic test_overflow();
    bitq_t m; int t; int e0; int bad = 0;
    clear_mon();
    e0 = err_cnt;
    for (int i = 0; i < 129; i++) m.push_back(1'($urandom));
    send_frame(m, 1'b0, t);
    checks++; if (io.err !== 1'b1) begin errors++; $display("FAIL ovf_err: err %b want 1 after bit 129", io.err); end
    checks++; if (io.din_rdy !== 1'b1) begin errors++; $display("FAIL ovf_rdy: din_rdy %b want 1", io.din_rdy); end
    repeat (20) @(posedge clk); #1;
    checks++; if (got.size() != 0) begin errors++; $display("FAIL ovf_no_out: %0d valid bits want 0", got.size()); end
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL ovf_pulses: %0d err pulses want 1", err_cnt - e0); end
    m.delete();
    for (int i = 0; i < 8; i++) m.push_back(1'($urandom));
    make_expected(m, cur_mask);
    send_frame(m, 1'b1, t);
    @(posedge clk); #1;
    checks++; if (io.dout_init !== exp_init) begin errors++; $display("FAIL ovf_next_init: got %b want %b", io.dout_init, exp_init); end
    wait_stream(24, 200);
    for (int i = 0; i < exp_q.size(); i++) if (i < got.size() && got[i] !== exp_q[i]) bad++;
    checks++; if (got.size() != 24 || bad != 0) begin errors++; $display("FAIL ovf_next_stream: %0d bits (%0d wrong) want 24", got.size(), bad); end
  endtask

  task automatic test_busy_err();
    bitq_t m; int t; int e0; int rdy_bad = 0; int bad = 0;
    clear_mon();
    for (int i = 0; i < 20; i++) m.push_back(1'($urandom));
    make_expected(m, cur_mask);
    send_frame(m, 1'b1, t);
    @(posedge clk); #1;
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) begin
      io.din = 1'($urandom); io.din_last = 1'($urandom); io.din_vld = 1'b1;
      if (io.din_rdy !== 1'b0) rdy_bad++;
      @(posedge clk); #1;
    end
    io.din_vld = 1'b0; io.din_last = 1'b0;
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL busy_rdy: din_rdy high %0d of 5 cycles want 0", rdy_bad); end
    wait_stream(36, 200);
    @(posedge clk); #1;
    checks++; if (err_cnt - e0 != 5) begin errors++; $display("FAIL busy_err: %0d err pulses want 5", err_cnt - e0); end
    for (int i = 0; i < exp_q.size(); i++) if (i < got.size() && got[i] !== exp_q[i]) bad++;
    checks++; if (got.size() != 36 || bad != 0 || last_cyc - first_cyc + 1 != 36)
      begin errors++; $display("FAIL busy_stream: %0d bits (%0d wrong) want 36 contiguous", got.size(), bad); end
    checks++; if (io.dout_init !== exp_init) begin errors++; $display("FAIL busy_init: got %b want %b", io.dout_init, exp_init); end
  endtask

  task automatic test_mid_reset();
    bitq_t m; int t; int bad = 0;
    clear_mon();
    for (int i = 0; i < 30; i++) m.push_back(1'($urandom));
    send_frame(m, 1'b1, t);
    wait_stream(5, 100);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (io.dout_vld !== 1'b0 || io.dout !== 1'b0) begin errors++; $display("FAIL mrst_dout: vld %b dout %b want 0 0", io.dout_vld, io.dout); end
    checks++; if (io.dout_init !== 6'b0) begin errors++; $display("FAIL mrst_init: got %b want 000000", io.dout_init); end
    checks++; if (io.din_rdy !== 1'b1) begin errors++; $display("FAIL mrst_rdy: got %b want 1", io.din_rdy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    repeat (50) @(posedge clk); #1;
    checks++; if (got.size() != 0) begin errors++; $display("FAIL mrst_resume: %0d valid bits after reset want 0", got.size()); end
    m.delete(); m.push_back(1'b1);
    make_expected(m, cur_mask);
    send_frame(m, 1'b1, t);
    @(posedge clk); #1;
    checks++; if (io.dout_init !== (6'b100001 ^ {cur_mask[0], cur_mask[1], cur_mask[2], cur_mask[3], cur_mask[4], cur_mask[5]}))
      begin errors++; $display("FAIL mrst_one_init: got %b want %b", io.dout_init, exp_init); end
    wait_stream(17, 100);
    for (int i = 0; i < exp_q.size(); i++) if (i < got.size() && got[i] !== exp_q[i]) bad++;
    checks++; if (got.size() != 17 || bad != 0) begin errors++; $display("FAIL mrst_one_stream: %0d bits (%0d wrong) want 17", got.size(), bad); end
  endtask

  task automatic test_random();
    bitq_t m; int t; int n; int bad; int e0;
    e0 = err_cnt;
    for (int f = 0; f < 6; f++) begin
      m.delete(); bad = 0;
      clear_mon();
`ifdef TBCE_CRC_MASK_EN
      set_mask(16'($urandom));
`endif
      n = (f == 0) ? 128 : $urandom_range(1, 128);
      for (int i = 0; i < n; i++) m.push_back(1'($urandom));
      make_expected(m, cur_mask);
      send_frame(m, 1'b1, t);
      @(posedge clk); #1;
      checks++; if (io.dout_init !== exp_init) begin errors++; $display("FAIL rnd_init[%0d]: got %b want %b", f, io.dout_init, exp_init); end
      wait_stream(n + 16, n + 60);
      checks++; if (first_cyc != t + 2) begin errors++; $display("FAIL rnd_latency[%0d]: first valid %0d want %0d", f, first_cyc, t + 2); end
      for (int i = 0; i < exp_q.size(); i++) if (i < got.size() && got[i] !== exp_q[i]) bad++;
      checks++; if (got.size() != n + 16 || bad != 0 || last_cyc - first_cyc + 1 != n + 16)
        begin errors++; $display("FAIL rnd_stream[%0d]: %0d bits (%0d wrong) want %0d contiguous", f, got.size(), bad, n + 16); end
    end
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL rnd_err: %0d unexpected err pulses want 0", err_cnt - e0); end
    set_mask(16'h0);
  endtask

  task automatic test_back_to_back();
    bitq_t a; bitq_t b; int t; int bad = 0;
    clear_mon();
    for (int i = 0; i < 10; i++) a.push_back(1'($urandom));
    for (int i = 0; i < 12; i++) b.push_back(1'($urandom));
    send_frame(a, 1'b1, t);
    wait_stream(26, 100);
    checks++; if (io.din_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy: din_rdy %b want 1 after last CRC bit", io.din_rdy); end
    clear_mon();
    make_expected(b, cur_mask);
    send_frame(b, 1'b1, t);
    @(posedge clk); #1;
    checks++; if (io.dout_init !== exp_init) begin errors++; $display("FAIL b2b_init: got %b want %b", io.dout_init, exp_init); end
    wait_stream(28, 100);
    for (int i = 0; i < exp_q.size(); i++) if (i < got.size() && got[i] !== exp_q[i]) bad++;
    checks++; if (got.size() != 28 || bad != 0) begin errors++; $display("FAIL b2b_stream: %0d bits (%0d wrong) want 28", got.size(), bad); end
  endtask

  initial begin
    test_reset();
    test_vector(16'h0000, 16'h31C3, 6'b110000);
    test_zeros();
    test_overflow();
    test_busy_err();
    test_mid_reset();
    test_random();
    test_back_to_back();
`ifdef TBCE_CRC_MASK_EN
    test_vector(16'hFFFF, 16'hCE3C, 6'b001111);
`endif
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
